// File: rtl/sd_read_seq.sv
// sd_read_seq: sequences multi-sector reads from an SD reader and packs the
// returned 16-bit halfwords into DDR_W-wide words for a DDR write port.
// One job = sd_sec_num sectors starting at sd_start_sec. A job ends with a
// one-cycle done pulse; err flags an abort or a per-sector idle timeout.
module sd_read_seq #(
    parameter int DDR_W   = 32,
    parameter int SEC_W   = 17,
    parameter int TMO_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       sd_start_sec,
    input  logic [SEC_W-1:0]  sd_sec_num,
    input  logic              rd_busy,
    input  logic              sd_rd_val_en,
    input  logic [15:0]       sd_rd_val_data,
    output logic              rd_sec_start,
    output logic [31:0]       rd_sec_addr,
    output logic              ddr_wr_en,
    output logic [DDR_W-1:0]  ddr_wr_data,
    output logic              ddr_wr_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int K     = DDR_W / 16;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam int HW_W  = SEC_W + 8;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic               busy_d0_reg;
    logic               busy_d1_reg;
    logic [SEC_W-1:0]   count_reg;
    logic [SEC_W-1:0]   sec_cnt_reg;
    logic [31:0]        addr_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic [IDX_W-1:0]   pack_idx_reg;
    logic [DDR_W-1:0]   pack_reg;
    logic [HW_W-1:0]    hw_cnt_reg;
    logic               wr_en_reg;
    logic [DDR_W-1:0]   wr_data_reg;
    logic               wr_last_reg;
    logic               err_reg;
    logic               zero_done_reg;

    logic               start_ok;
    logic               job_run;
    logic               abort_hit;
    logic               timeout_hit;
    logic               sec_done;
    logic               last_sec;
    logic               hw_accept;
    logic               word_done;
    logic               hw_final;
    logic [DDR_W-1:0]   word_next;

    // Job-control decode shared by the FSM and the datapath
    assign start_ok    = (state_reg == S_IDLE) && start;
    assign job_run     = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
    assign abort_hit   = job_run && abort;
    assign timeout_hit = (state_reg == S_WAIT) && (tmo_cnt_reg == TMO_MAX);
    // Falling edge of the twice-registered reader busy marks a finished sector
    assign sec_done    = busy_d1_reg && !busy_d0_reg;
    assign last_sec    = (sec_cnt_reg + SEC_W'(1)) == count_reg;
    // Halfwords are dropped in IDLE and once the job has failed, so nothing
    // is written after an abort or timeout
    assign hw_accept   = sd_rd_val_en && (state_reg != S_IDLE) && !err_reg
                         && !abort_hit && !timeout_hit;
    assign word_done   = hw_accept && (pack_idx_reg == IDX_LAST);
    assign hw_final    = (hw_cnt_reg + HW_W'(1)) == {count_reg, 8'h00};

    // Incoming halfword merged into its slot of the pack buffer
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_slot
            assign word_next[gi*16 +: 16] = (pack_idx_reg == IDX_W'(gi))
                                            ? sd_rd_val_data
                                            : pack_reg[gi*16 +: 16];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; abort takes priority over sector completion
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && (sd_sec_num != '0)) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = abort ? S_FIN : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_next = S_FIN;
                end else if (sec_done) begin
                    state_next = last_sec ? S_FIN : S_ISSUE;
                end else if (timeout_hit) begin
                    state_next = S_FIN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs; a zero-sector job pulses done without ever raising busy
    always_comb begin
        rd_sec_start = (state_reg == S_ISSUE);
        busy         = (state_reg != S_IDLE);
        done         = (state_reg == S_FIN) || zero_done_reg;
    end

    assign rd_sec_addr = addr_reg;
    assign ddr_wr_en   = wr_en_reg;
    assign ddr_wr_data = wr_data_reg;
    assign ddr_wr_last = wr_last_reg;
    assign err         = err_reg;

    // Job registers: busy synchroniser, counters, address, error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_d0_reg   <= 1'b0;
            busy_d1_reg   <= 1'b0;
            count_reg     <= '0;
            sec_cnt_reg   <= '0;
            addr_reg      <= '0;
            tmo_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            busy_d0_reg   <= rd_busy;
            busy_d1_reg   <= busy_d0_reg;
            zero_done_reg <= start_ok && (sd_sec_num == '0);

            if (start_ok) begin
                err_reg <= 1'b0;
                if (sd_sec_num != '0) begin
                    count_reg   <= sd_sec_num;
                    addr_reg    <= sd_start_sec;
                    sec_cnt_reg <= '0;
                end
            end else if (abort_hit || timeout_hit) begin
                err_reg <= 1'b1;
            end

            if ((state_reg == S_WAIT) && !abort && sec_done) begin
                sec_cnt_reg <= sec_cnt_reg + SEC_W'(1);
                if (!last_sec) begin
                    addr_reg <= addr_reg + 32'd1;
                end
            end

            if ((state_reg == S_ISSUE) || sd_rd_val_en) begin
                tmo_cnt_reg <= '0;
            end else if ((state_reg == S_WAIT) && (tmo_cnt_reg != TMO_MAX)) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end
        end
    end

    // Halfword packer: emits a word the cycle after its last halfword arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_idx_reg <= '0;
            pack_reg     <= '0;
            hw_cnt_reg   <= '0;
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= '0;
            wr_last_reg  <= 1'b0;
        end else begin
            wr_en_reg <= word_done;
            if (start_ok) begin
                pack_idx_reg <= '0;
                hw_cnt_reg   <= '0;
            end else if (hw_accept) begin
                pack_reg     <= word_next;
                hw_cnt_reg   <= hw_cnt_reg + HW_W'(1);
                pack_idx_reg <= word_done ? '0 : pack_idx_reg + IDX_W'(1);
            end
            if (word_done) begin
                wr_data_reg <= word_next;
                wr_last_reg <= hw_final;
            end else begin
                wr_last_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sd_read_seq.md
SD_READ_SEQ -- requirements
Module: sd_read_seq

Interface
REQ-001 Parameter DDR_W, 32, DDR write-data width in bits; SHALL be 16, 32, 64 or 128.
REQ-002 Parameter SEC_W, 17, width of sector-count input and sector counter.
REQ-003 Parameter TMO_CYC, 65535, max idle cycles per sector before timeout; counter width SHALL be $clog2(TMO_CYC+1).
REQ-004 clk  in  1  system clock; sole clock domain.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  job request, sampled in IDLE only.
REQ-007 abort  in  1  cancel running job.
REQ-008 sd_start_sec  in  32  first sector address, latched at start.
REQ-009 sd_sec_num  in  SEC_W  sector count, latched at start.
REQ-010 rd_busy  in  1  SD reader busy.
REQ-011 sd_rd_val_en  in  1  SD halfword valid.
REQ-012 sd_rd_val_data  in  16  SD halfword.
REQ-013 rd_sec_start  out  1  one-cycle sector-read request.
REQ-014 rd_sec_addr  out  32  sector address for the current request.
REQ-015 ddr_wr_en  out  1  packed word valid.
REQ-016 ddr_wr_data  out  DDR_W  packed word.
REQ-017 ddr_wr_last  out  1  marks final word of job, coincident with ddr_wr_en.
REQ-018 busy  out  1  high from accepted start until done.
REQ-019 done  out  1  one-cycle job-end pulse.
REQ-020 err  out  1  sticky timeout/abort flag, cleared by next accepted start.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, FIN; one state per cycle of transition.
REQ-022 IDLE: start=1 and sd_sec_num!=0 SHALL latch count/address, clear sector counter, pack count and err, go ISSUE.
REQ-023 IDLE: start=1 and sd_sec_num==0 SHALL produce done=1 next cycle, no rd_sec_start, err=0.
REQ-024 ISSUE: rd_sec_start SHALL be 1 for exactly one cycle with rd_sec_addr = start + sectors completed; then WAIT.
REQ-025 rd_busy SHALL be registered twice (d0,d1); sector complete = d1 & ~d0.
REQ-026 WAIT: on sector complete, counter increments; if counter+1 == latched count go FIN, else address+1 and go ISSUE.
REQ-027 Sector counter arithmetic SHALL be SEC_W wide; latched count 2^SEC_W-1 SHALL complete without wrap.
REQ-028 Packing: K = DDR_W/16 halfwords per word; first halfword received occupies bits [15:0], next [31:16], etc.
REQ-029 ddr_wr_en SHALL pulse exactly one cycle after the sd_rd_val_en completing the K-th halfword; DDR_W=16 gives 1-cycle passthrough.
REQ-030 Halfwords per sector (256) SHALL be a multiple of K, so pack boundary aligns to sector boundary; pack index resets at start.
REQ-031 ddr_wr_last SHALL be 1 on the final word of the final sector only (halfword count == count*256).
REQ-032 sd_rd_val_en SHALL be accepted in any non-IDLE state; data arriving in IDLE is dropped.
REQ-033 Timeout counter SHALL reset on ISSUE and on each sd_rd_val_en; reaching TMO_CYC in WAIT sets err=1 and goes FIN.
REQ-034 abort=1 in ISSUE or WAIT SHALL set err=1 and go FIN next cycle; abort in IDLE/FIN ignored.
REQ-035 FIN: done=1 for one cycle, busy=0 following cycle, return IDLE; no further ddr_wr_en issued after FIN on error.
REQ-036 start while busy SHALL be ignored; abort and sector complete in same cycle: abort wins.

Reset
REQ-037 rst_n=0 at a clk edge SHALL force IDLE and zero rd_sec_start, rd_sec_addr, ddr_wr_en, ddr_wr_data, ddr_wr_last, busy, done, err, all counters, busy sync regs.
REQ-038 Reset mid-job SHALL abandon the job with no done pulse; partial pack word discarded.

Verification
REQ-039 DDR_W=32, start_sec=0x100, num=2, 512 halfwords 0..511 -> addrs 0x100,0x101 one pulse each; 256 writes, word0=0x0001_0000, last only on word 255, one done, err=0.
REQ-040 num=0 -> done one cycle after start, no rd_sec_start, no writes, busy never 1.
REQ-041 TMO_CYC=100, rd_busy stuck high after first sector request -> err=1 and done at cycle 100 of inactivity, busy falls.
REQ-042 abort during sector 1 of 3 -> done next cycle, err=1, no further rd_sec_start or writes.
REQ-043 DDR_W=16, num=1 -> 256 writes each one cycle after its sd_rd_val_en, data identical, last on 256th.
REQ-044 rst_n low for one cycle mid-sector -> all outputs zero next cycle, subsequent start runs a clean job from new sd_start_sec.
